// File: rtl/v_ce_pkg.sv
// Shared types and sizing helpers for the clock-enabled serial capture link.
package v_ce_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/v_ce_serial_tx_if.sv
// Parallel-load handshake and serial outputs of the transmitter.
interface v_ce_serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] DIN;
    logic             LOAD;
    logic             READY;
    logic             SO;
    logic             CE_O;
    logic             BUSY;
    logic             DONE;

    // Data source / observer side
    modport master (
        output DIN, LOAD,
        input  READY, SO, CE_O, BUSY, DONE
    );

    // Transmitter side
    modport slave (
        input  DIN, LOAD,
        output READY, SO, CE_O, BUSY, DONE
    );
endinterface

// File: rtl/v_ce_gen.sv
// DIV-cycle clock-enable generator: tick is high on the last cycle of each
// DIV-cycle period while run is high. Shared with the matching receiver.
module v_ce_gen
    import v_ce_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic run,
    output logic tick
);
    localparam int unsigned   CW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Period counter: held at zero when idle or restarted, wraps after LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);
endmodule

// File: rtl/v_ce_serial_tx.sv
// Serial transmitter: accepts a word on LOAD/READY and shifts it out on SO,
// with one CE_O strobe at the end of every bit period.
module v_ce_serial_tx
    import v_ce_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic               C,
    input  logic               CLR_N,
    v_ce_serial_tx_if.slave    bus
);
    localparam int unsigned   BW   = clog2(WIDTH + 1);
    localparam logic [BW-1:0] BITS = BW'(WIDTH);
    localparam logic [BW-1:0] ONE  = BW'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic             done_q;
    logic             tick;
    logic             shifting;
    logic             accept;
    logic             last_strobe;

    assign shifting = (state == ST_SHIFT);

    v_ce_gen #(.DIV(DIV)) u_gen (
        .clk     (C),
        .rst_n   (CLR_N),
        .restart (accept),
        .run     (shifting),
        .tick    (tick)
    );

    // State register
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, leave SHIFT on the final strobe
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        last_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.LOAD) begin
                    accept    = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick && (bit_cnt == ONE)) begin
                    last_strobe = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift register, bit counter and end-of-frame pulse.
    // Zero fill means the register is empty after a frame, so SO idles low
    // straight from the register without an extra output mux.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            sreg    <= '0;
            bit_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_strobe;
            if (accept) begin
                sreg    <= bus.DIN;
                bit_cnt <= BITS;
            end else if (tick) begin
                if (MSB_FIRST != 0) begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end else begin
                    sreg <= {1'b0, sreg[WIDTH-1:1]};
                end
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    assign bus.READY = (state == ST_IDLE);
    assign bus.BUSY  = shifting;
    assign bus.CE_O  = tick;
    assign bus.DONE  = done_q;
    assign bus.SO    = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
endmodule

// File: tb/tb_v_ce_serial_tx.sv
// Bench for v_ce_serial_tx: three configurations (DIV=4 MSB first, DIV=4
// LSB first, DIV=1 MSB first) against a frame-timeline reference model and
// a word scoreboard fed by a downstream clock-enabled capture register.
module tb_v_ce_serial_tx;
    localparam int unsigned W = 8;

    logic         C      = 1'b0;
    logic         CLR_N  = 1'b0;
    logic         load0  = 1'b0;
    logic [W-1:0] din0   = '0;
    logic         end_chk = 1'b0;
    int           n_checks = 0;
    int           n_fails  = 0;

    always #5 C = ~C;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned D = (g == 2) ? 1 : 4;
        localparam int unsigned M = (g == 1) ? 0 : 1;

        logic         ld_r  = 1'b0;
        logic [W-1:0] din_r = '0;

        v_ce_serial_tx_if #(.WIDTH(W)) bus ();
        assign bus.LOAD = (g == 0) ? load0 : ld_r;
        assign bus.DIN  = (g == 0) ? din0  : din_r;

        v_ce_serial_tx #(.WIDTH(W), .DIV(D), .MSB_FIRST(M)) dut (
            .C     (C),
            .CLR_N (CLR_N),
            .bus   (bus)
        );

        // Reference: a frame is W*D cycles long, bit k occupies cycles
        // k*D..k*D+D-1 after acceptance, strobe on the last cycle of each.
        bit           m_busy = 1'b0;
        bit           m_done = 1'b0;
        int           m_t    = 0;
        logic [W-1:0] m_word = '0;
        bit           exp_bits[$];
        logic [W-1:0] word_q[$];
        logic [W-1:0] cap = '0;

        function automatic bit nth_bit(input logic [W-1:0] w, input int k);
            if (M != 0) return w[W-1-k];
            return w[k];
        endfunction

        // Frame timeline model; pushes expected bits and words on acceptance
        always @(posedge C or negedge CLR_N) begin
            if (!CLR_N) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
                m_t    <= 0;
                exp_bits.delete();
                word_q.delete();
            end else begin
                m_done <= 1'b0;
                if (m_busy) begin
                    if (m_t == int'(W * D) - 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end else if (bus.LOAD) begin
                    m_busy <= 1'b1;
                    m_t    <= 0;
                    m_word <= bus.DIN;
                    for (int k = 0; k < int'(W); k++) exp_bits.push_back(nth_bit(bus.DIN, k));
                    word_q.push_back(bus.DIN);
                end
            end
        end

        // Downstream clock-enabled capture flop chain (D=SO, CE=CE_O)
        always @(posedge C or negedge CLR_N) begin
            if (!CLR_N) cap <= '0;
            else if (bus.CE_O) cap <= (M != 0) ? {cap[W-2:0], bus.SO} : {bus.SO, cap[W-1:1]};
        end

        // Monitor: cycle timing checks plus scoreboard pops on CE_O and DONE
        always @(negedge C) begin
            chk($sformatf("cfg%0d ready", g), bus.READY, !m_busy);
            chk($sformatf("cfg%0d busy", g), bus.BUSY, m_busy);
            chk($sformatf("cfg%0d ce_o", g), bus.CE_O, m_busy && ((m_t % int'(D)) == int'(D) - 1));
            chk($sformatf("cfg%0d done", g), bus.DONE, m_done);
            chk($sformatf("cfg%0d so", g), bus.SO, m_busy ? nth_bit(m_word, m_t / int'(D)) : 1'b0);
            if (bus.CE_O) begin
                if (exp_bits.size() == 0) chk($sformatf("cfg%0d unexpected strobe", g), 1, 0);
                else chk($sformatf("cfg%0d strobed bit", g), bus.SO, exp_bits.pop_front());
            end
            if (bus.DONE) begin
                if (word_q.size() == 0) chk($sformatf("cfg%0d unexpected done", g), 1, 0);
                else chk($sformatf("cfg%0d captured word", g), cap, word_q.pop_front());
            end
        end

        // Nothing left outstanding once stimulus has drained
        always @(posedge end_chk) begin
            chk($sformatf("cfg%0d leftover bits", g), exp_bits.size(), 0);
            chk($sformatf("cfg%0d leftover words", g), word_q.size(), 0);
        end

        if (g != 0) begin : g_drv
            initial begin
                @(posedge CLR_N);
                @(negedge C);
                ld_r  = 1'b1;
                din_r = (g == 1) ? 8'h01 : 8'hFF;
                @(negedge C);
                ld_r  = 1'b0;
                din_r = W'($urandom);
                repeat (W * D + 4) @(negedge C);
                repeat (1500) begin
                    @(negedge C);
                    ld_r  = ($urandom_range(0, 99) < 30);
                    din_r = W'($urandom);
                end
                @(negedge C);
                ld_r = 1'b0;
            end
        end
    end

    task automatic send0(input logic [W-1:0] w);
        load0 = 1'b1;
        din0  = w;
        @(negedge C);
        load0 = 1'b0;
        din0  = W'($urandom);
    endtask

    task automatic chk_reset_now(input string tag);
        chk({tag, " ready"}, g_cfg[0].bus.READY, 1);
        chk({tag, " so"},    g_cfg[0].bus.SO,    0);
        chk({tag, " ce_o"},  g_cfg[0].bus.CE_O,  0);
        chk({tag, " busy"},  g_cfg[0].bus.BUSY,  0);
        chk({tag, " done"},  g_cfg[0].bus.DONE,  0);
    endtask

    initial begin
        repeat (3) @(negedge C);
        chk_reset_now("por");
        CLR_N = 1'b1;

        // Single frame of 0xA5
        @(negedge C);
        send0(8'hA5);
        repeat (36) @(negedge C);

        // 0x3C, with a LOAD of 0xFF landing on edge 10 of the frame
        send0(8'h3C);
        repeat (9) @(negedge C);
        send0(8'hFF);
        repeat (30) @(negedge C);

        // LOAD held: 0x12 then 0x34 back to back
        load0 = 1'b1;
        din0  = 8'h12;
        @(negedge C);
        din0 = 8'h34;
        repeat (40) @(negedge C);
        load0 = 1'b0;
        repeat (40) @(negedge C);

        // Asynchronous reset in the middle of a frame
        send0(8'hC3);
        repeat (13) @(posedge C);
        #2 CLR_N = 1'b0;
        #1 chk_reset_now("midframe reset");
        repeat (2) @(negedge C);
        CLR_N = 1'b1;
        @(negedge C);
        send0(8'h5A);
        repeat (36) @(negedge C);

        // Random traffic
        repeat (1500) begin
            load0 = ($urandom_range(0, 99) < 30);
            din0  = W'($urandom);
            @(negedge C);
        end
        load0 = 1'b0;
        repeat (60) @(negedge C);

        end_chk = 1'b1;
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
